// File: rtl/pipeline_if_arb_rr.sv
// Packet-aware round-robin arbiter: NUM_IN stream requesters share one registered output stage.
// A requester keeps the grant from its first beat until its eop beat transfers.
module pipeline_if_arb_rr #(
   parameter int NUM_IN    = 4,
   parameter int DAT_BYTS  = 8,
   parameter int CTL_BITS  = 8,
   localparam int MOD_BITS = $clog2(DAT_BYTS),
   localparam int SRC_BITS = $clog2(NUM_IN)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [NUM_IN*DAT_BYTS*8-1:0] i_dat,
   input  logic [NUM_IN-1:0]            i_val,
   input  logic [NUM_IN-1:0]            i_sop,
   input  logic [NUM_IN-1:0]            i_eop,
   input  logic [NUM_IN-1:0]            i_err,
   input  logic [NUM_IN*MOD_BITS-1:0]   i_mod,
   input  logic [NUM_IN*CTL_BITS-1:0]   i_ctl,
   output logic [NUM_IN-1:0]            i_rdy,
   output logic [DAT_BYTS*8-1:0]        o_dat,
   output logic                         o_val,
   output logic                         o_sop,
   output logic                         o_eop,
   output logic                         o_err,
   output logic [MOD_BITS-1:0]          o_mod,
   output logic [CTL_BITS-1:0]          o_ctl,
   output logic [SRC_BITS-1:0]          o_src,
   input  logic                         o_rdy
);

   localparam int DAT_W = DAT_BYTS * 8;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                r_state;
   state_t                w_stateNext;
   logic [SRC_BITS-1:0]   r_last;
   logic [SRC_BITS-1:0]   r_lock;
   logic [SRC_BITS-1:0]   w_gnt;
   logic                  w_gntFound;
   logic [SRC_BITS-1:0]   w_sel;
   logic                  w_selOk;
   logic                  w_adv;
   logic                  w_xfer;
   logic                  w_eop;
   logic [NUM_IN-1:0]     w_rdy;

   logic [DAT_W-1:0]      r_dat;
   logic                  r_val;
   logic                  r_sop;
   logic                  r_eop;
   logic                  r_err;
   logic [MOD_BITS-1:0]   r_mod;
   logic [CTL_BITS-1:0]   r_ctl;
   logic [SRC_BITS-1:0]   r_src;

   assign w_adv = ~r_val | o_rdy;

   // Circular search for the first valid requester after the last packet winner.
   always_comb begin : gntSearch
      int w_idx;
      w_idx      = 0;
      w_gnt      = '0;
      w_gntFound = 1'b0;
      for (int k = 1; k <= NUM_IN; k++) begin
         w_idx = (int'(r_last) + k) % NUM_IN;
         if (!w_gntFound && i_val[SRC_BITS'(w_idx)]) begin
            w_gnt      = SRC_BITS'(w_idx);
            w_gntFound = 1'b1;
         end
      end
   end

   always_comb begin
      w_sel   = (r_state == LOCKED) ? r_lock : w_gnt;
      w_selOk = (r_state == LOCKED) | w_gntFound;
      w_rdy   = '0;
      if (w_selOk && w_adv && !i_rst) begin
         w_rdy[w_sel] = 1'b1;
      end
      w_xfer = w_rdy[w_sel] & i_val[w_sel];
      w_eop  = i_eop[w_sel];
   end

   assign i_rdy = w_rdy;

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_xfer && !w_eop) w_stateNext = LOCKED;
         LOCKED:  if (w_xfer && w_eop)  w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // The pointer moves only on the first beat of a packet, so a packet counts once.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_last  <= SRC_BITS'(NUM_IN - 1);
         r_lock  <= '0;
      end else begin
         r_state <= w_stateNext;
         if (r_state == IDLE && w_xfer) begin
            r_last <= w_gnt;
            r_lock <= w_gnt;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_dat <= '0;
         r_val <= 1'b0;
         r_sop <= 1'b0;
         r_eop <= 1'b0;
         r_err <= 1'b0;
         r_mod <= '0;
         r_ctl <= '0;
         r_src <= '0;
      end else if (w_adv) begin
         r_val <= w_xfer;
         if (w_xfer) begin
            r_dat <= i_dat[int'(w_sel)*DAT_W +: DAT_W];
            r_sop <= i_sop[w_sel];
            r_eop <= i_eop[w_sel];
            r_err <= i_err[w_sel];
            r_mod <= i_mod[int'(w_sel)*MOD_BITS +: MOD_BITS];
            r_ctl <= i_ctl[int'(w_sel)*CTL_BITS +: CTL_BITS];
            r_src <= w_sel;
         end
      end
   end

   assign o_dat = r_dat;
   assign o_val = r_val;
   assign o_sop = r_sop;
   assign o_eop = r_eop;
   assign o_err = r_err;
   assign o_mod = r_mod;
   assign o_ctl = r_ctl;
   assign o_src = r_src;

endmodule

// File: tb/tb_pipeline_if_arb_rr.sv
// Bench for pipeline_if_arb_rr: per-requester packet queues, a cycle reference model of the
// arbitration rules, and an output scoreboard checking order, interleaving and fairness.
module tb_pipeline_if_arb_rr;

   localparam int NUM_IN   = 4;
   localparam int DAT_BYTS = 8;
   localparam int CTL_BITS = 8;
   localparam int MOD_BITS = 3;
   localparam int SRC_BITS = 2;
   localparam int DW       = 64;

   typedef struct {
      logic [DW-1:0]       dat;
      logic                sop;
      logic                eop;
      logic                err;
      logic [MOD_BITS-1:0] mod;
      logic [CTL_BITS-1:0] ctl;
      int                  delay;
   } beat_t;

   logic                       clock;
   logic                       reset;
   logic [NUM_IN*DW-1:0]       inDat;
   logic [NUM_IN-1:0]          inVal;
   logic [NUM_IN-1:0]          inSop;
   logic [NUM_IN-1:0]          inEop;
   logic [NUM_IN-1:0]          inErr;
   logic [NUM_IN*MOD_BITS-1:0] inMod;
   logic [NUM_IN*CTL_BITS-1:0] inCtl;
   logic [NUM_IN-1:0]          inRdy;
   logic [DW-1:0]              outDat;
   logic                       outVal;
   logic                       outSop;
   logic                       outEop;
   logic                       outErr;
   logic [MOD_BITS-1:0]        outMod;
   logic [CTL_BITS-1:0]        outCtl;
   logic [SRC_BITS-1:0]        outSrc;
   logic                       outRdy;

   pipeline_if_arb_rr #(.NUM_IN(NUM_IN), .DAT_BYTS(DAT_BYTS), .CTL_BITS(CTL_BITS)) dut (
      .i_clk(clock), .i_rst(reset),
      .i_dat(inDat), .i_val(inVal), .i_sop(inSop), .i_eop(inEop), .i_err(inErr),
      .i_mod(inMod), .i_ctl(inCtl), .i_rdy(inRdy),
      .o_dat(outDat), .o_val(outVal), .o_sop(outSop), .o_eop(outEop), .o_err(outErr),
      .o_mod(outMod), .o_ctl(outCtl), .o_src(outSrc), .o_rdy(outRdy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Bench-side traffic state
   beat_t srcQ[NUM_IN][$];
   beat_t expOrder[NUM_IN][$];
   bit    offering[NUM_IN];
   int    waitCnt[NUM_IN];
   int    waitPk[NUM_IN];
   int    stallCnt;
   int    rdyProb;

   // Reference model of the registered output and arbitration state
   int                  mOwner;
   int                  mLast;
   logic                mVal, mSop, mEop, mErr;
   logic [DW-1:0]       mDat;
   logic [MOD_BITS-1:0] mMod;
   logic [CTL_BITS-1:0] mCtl;
   int                  mSrc;

   bit sbInPkt;
   int sbSrc;
   int srcLog[$];
   int ctlLog[$];

   int checks;
   int fails;

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic resetModel();
      mOwner = -1;
      mLast  = NUM_IN - 1;
      mVal = 1'b0; mSop = 1'b0; mEop = 1'b0; mErr = 1'b0;
      mDat = '0;   mMod = '0;   mCtl = '0;   mSrc = 0;
   endtask

   task automatic clearTraffic();
      for (int n = 0; n < NUM_IN; n++) begin
         srcQ[n].delete();
         expOrder[n].delete();
         offering[n] = 1'b0;
         waitCnt[n]  = 0;
         waitPk[n]   = 0;
      end
      sbInPkt = 1'b0;
   endtask

   function automatic int pendingBeats();
      int s = 0;
      for (int n = 0; n < NUM_IN; n++) s += srcQ[n].size() + expOrder[n].size();
      return s;
   endfunction

   task automatic pushPacket(input int req, input int len, input logic [CTL_BITS-1:0] ctlBase,
                             input int gapAt, input bit randDelay, input logic [DW-1:0] datSeed);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.dat   = (datSeed == 0) ? {$urandom, $urandom} : datSeed + DW'(i);
         b.sop   = (i == 0);
         b.eop   = (i == len - 1);
         b.err   = 1'($urandom_range(1));
         b.mod   = MOD_BITS'($urandom);
         b.ctl   = ctlBase + CTL_BITS'(i);
         b.delay = randDelay ? (($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0)
                             : ((i == gapAt) ? 1 : 0);
         srcQ[req].push_back(b);
         expOrder[req].push_back(b);
      end
   endtask

   // One clock cycle: drive at posedge+1, check ready at posedge+2, check outputs at next posedge+1.
   task automatic applyStimulus();
      logic [NUM_IN-1:0] expRdy;
      int    cand;
      bit    candOk, adv, xfer;
      beat_t b;
      beat_t e;
      for (int n = 0; n < NUM_IN; n++) begin
         if (!offering[n] && srcQ[n].size() > 0) begin
            if (waitCnt[n] >= srcQ[n][0].delay) begin
               offering[n] = 1'b1;
               waitCnt[n]  = 0;
            end else begin
               waitCnt[n]++;
            end
         end
         inVal[n] = offering[n];
         if (offering[n]) begin
            b = srcQ[n][0];
            inDat[n*DW +: DW] = b.dat;
            inSop[n] = b.sop; inEop[n] = b.eop; inErr[n] = b.err;
            inMod[n*MOD_BITS +: MOD_BITS] = b.mod;
            inCtl[n*CTL_BITS +: CTL_BITS] = b.ctl;
         end else begin
            inDat[n*DW +: DW] = {$urandom, $urandom};
            inSop[n] = 1'b0; inEop[n] = 1'b0; inErr[n] = 1'b0;
            inMod[n*MOD_BITS +: MOD_BITS] = '0;
            inCtl[n*CTL_BITS +: CTL_BITS] = '0;
         end
      end
      if (stallCnt > 0) begin
         outRdy = 1'b0;
         stallCnt--;
      end else begin
         outRdy = ($urandom_range(99) < rdyProb);
      end
      #1;
      adv    = !mVal || outRdy;
      candOk = 1'b0;
      cand   = 0;
      if (!reset) begin
         if (mOwner >= 0) begin
            cand   = mOwner;
            candOk = 1'b1;
         end else begin
            for (int k = 1; k <= NUM_IN; k++) begin
               if (!candOk && offering[(mLast + k) % NUM_IN]) begin
                  cand   = (mLast + k) % NUM_IN;
                  candOk = 1'b1;
               end
            end
         end
      end
      expRdy = (candOk && adv) ? NUM_IN'(1 << cand) : '0;
      checkOutput("rdy", DW'(inRdy), DW'(expRdy));
      xfer = candOk && adv && offering[cand];
      for (int m = 0; m < NUM_IN; m++) begin
         if (!reset && inVal[m] && inRdy[m] && srcQ[m].size() > 0 && srcQ[m][0].sop) begin
            checkOutput("fairWait", DW'(waitPk[m] <= NUM_IN - 1), 1);
            waitPk[m] = 0;
            for (int n = 0; n < NUM_IN; n++)
               if (n != m && offering[n] && srcQ[n][0].sop) waitPk[n]++;
         end
      end
      if (!reset && outVal && outRdy) begin
         if (expOrder[outSrc].size() == 0) begin
            checkOutput("extraBeat", DW'(outSrc), DW'(NUM_IN));
         end else begin
            e = expOrder[outSrc].pop_front();
            checkOutput("sbDat", outDat, e.dat);
            checkOutput("sbCtl", DW'(outCtl), DW'(e.ctl));
            checkOutput("sbEop", DW'(outEop), DW'(e.eop));
         end
         if (sbInPkt) checkOutput("interleave", DW'(outSrc), DW'(sbSrc));
         sbInPkt = !outEop;
         sbSrc   = int'(outSrc);
         srcLog.push_back(int'(outSrc));
         ctlLog.push_back(int'(outCtl));
      end
      @(posedge clock);
      if (reset) begin
         resetModel();
      end else if (adv) begin
         mVal = xfer;
         if (xfer) begin
            b = srcQ[cand].pop_front();
            offering[cand] = 1'b0;
            mDat = b.dat; mSop = b.sop; mEop = b.eop; mErr = b.err;
            mMod = b.mod; mCtl = b.ctl; mSrc = cand;
            if (mOwner < 0) begin
               mLast = cand;
               if (!b.eop) mOwner = cand;
            end else if (b.eop) begin
               mOwner = -1;
            end
         end
      end
      #1;
      checkOutput("val", DW'(outVal), DW'(mVal));
      if (mVal) begin
         checkOutput("dat", outDat, mDat);
         checkOutput("sop", DW'(outSop), DW'(mSop));
         checkOutput("eop", DW'(outEop), DW'(mEop));
         checkOutput("err", DW'(outErr), DW'(mErr));
         checkOutput("mod", DW'(outMod), DW'(mMod));
         checkOutput("ctl", DW'(outCtl), DW'(mCtl));
         checkOutput("src", DW'(outSrc), DW'(mSrc));
      end
   endtask

   task automatic runUntilDrained(input int budget, input string tag);
      int c = 0;
      while (pendingBeats() > 0 && c < budget) begin
         applyStimulus();
         c++;
      end
      checkOutput({tag, "Drain"}, DW'(pendingBeats()), 0);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL timeout: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int expSeq[$];
      int c;
      checks = 0; fails = 0;
      reset = 1'b1; outRdy = 1'b0; stallCnt = 0; rdyProb = 100;
      inDat = '0; inVal = '0; inSop = '0; inEop = '0; inErr = '0; inMod = '0; inCtl = '0;
      resetModel();
      clearTraffic();
      @(posedge clock);
      #1;

      // Reset then idle, then a single beat from requester 2
      for (int i = 0; i < 3; i++) applyStimulus();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) applyStimulus();
      pushPacket(2, 1, 8'h01, -1, 1'b0, 64'hAA);
      applyStimulus();
      checkOutput("firstVal", DW'(outVal), 1);
      checkOutput("firstDat", outDat, 64'hAA);
      checkOutput("firstSrc", DW'(outSrc), 2);
      runUntilDrained(20, "single");

      // Packet lock: requester 1 sends 4 beats with a gap, requester 0 always valid
      srcLog.delete();
      pushPacket(1, 4, 8'h20, 2, 1'b0, 0);
      pushPacket(0, 1, 8'h30, -1, 1'b0, 0);
      pushPacket(0, 1, 8'h31, -1, 1'b0, 0);
      runUntilDrained(40, "lock");
      expSeq = '{0, 1, 1, 1, 1, 0};
      checkOutput("lockLen", DW'(srcLog.size()), DW'(expSeq.size()));
      for (int i = 0; i < expSeq.size(); i++)
         checkOutput("lockSeq", DW'((i < srcLog.size()) ? srcLog[i] : -1), DW'(expSeq[i]));

      // Backpressure: 5-cycle stall during a 3-beat packet from requester 3
      ctlLog.delete();
      pushPacket(3, 3, 8'h10, -1, 1'b0, 0);
      applyStimulus();
      stallCnt = 5;
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkOutput("bpHoldCtl", DW'(outCtl), 8'h10);
         checkOutput("bpHoldVal", DW'(outVal), 1);
      end
      runUntilDrained(40, "bp");
      for (int i = 0; i < 3; i++)
         checkOutput("bpCtl", DW'((i < ctlLog.size()) ? ctlLog[i] : -1), DW'(8'h10 + i));

      // Async reset mid-packet, then all requesters valid
      pushPacket(2, 4, 8'h40, -1, 1'b0, 0);
      c = 0;
      while (srcQ[2].size() > 2 && c < 20) begin
         applyStimulus();
         c++;
      end
      checkOutput("rstSetup", DW'(srcQ[2].size()), 2);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("rstValNow", DW'(outVal), 0);
      checkOutput("rstRdyNow", DW'(inRdy), 0);
      resetModel();
      clearTraffic();
      @(posedge clock);
      #1;
      applyStimulus();
      reset = 1'b0;
      srcLog.delete();
      pushPacket(0, 1, 8'h50, -1, 1'b0, 0);
      pushPacket(0, 1, 8'h54, -1, 1'b0, 0);
      pushPacket(1, 1, 8'h51, -1, 1'b0, 0);
      pushPacket(1, 1, 8'h55, -1, 1'b0, 0);
      pushPacket(2, 1, 8'h52, -1, 1'b0, 0);
      pushPacket(3, 1, 8'h53, -1, 1'b0, 0);
      runUntilDrained(40, "rr");
      expSeq = '{0, 1, 2, 3, 0, 1};
      checkOutput("rrLen", DW'(srcLog.size()), DW'(expSeq.size()));
      for (int i = 0; i < expSeq.size(); i++)
         checkOutput("rrSeq", DW'((i < srcLog.size()) ? srcLog[i] : -1), DW'(expSeq[i]));

      // Randomised traffic
      rdyProb = 70;
      for (int p = 0; p < 1000; p++)
         pushPacket(int'($urandom_range(NUM_IN - 1)), int'($urandom_range(8, 1)),
                    CTL_BITS'($urandom), -1, 1'b1, 0);
      runUntilDrained(60000, "random");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
